// File: rtl/basilisk_float_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : basilisk_float_mem_responder_pkg
// Description : Shared types and constants for the Basilisk float memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package basilisk_float_mem_responder_pkg;

    typedef logic [31:0] basilisk_mem_word_t;
    typedef logic [3:0]  basilisk_mem_be_t;

    localparam int BASILISK_MEM_DEFAULT_LATENCY = 1;
    localparam int c_mem_data_width             = 32;
    localparam int c_mem_be_width               = c_mem_data_width / 8;

endpackage
`default_nettype wire

// File: rtl/basilisk_float_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : std_mem_intf
// Description : Valid/ready memory request/result bus with byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
interface std_mem_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    valid;
    logic                    ready;
    logic                    read_enable;
    logic [DATA_WIDTH/8-1:0] write_enable;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;

    modport master (
        output valid, read_enable, write_enable, addr, data,
        input  ready
    );

    modport slave (
        input  valid, read_enable, write_enable, addr, data,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/basilisk_float_mem_queue.sv
`default_nettype none
// ============================================================================
// Module      : basilisk_float_mem_queue
// Description : Synchronous show-ahead response FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module basilisk_float_mem_queue
    import basilisk_float_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  basilisk_mem_word_t i_data,
    input  logic               i_pop,
    output logic               o_valid,
    output basilisk_mem_word_t o_data,
    output logic [COUNT_W-1:0] o_count
);
    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] c_depth = COUNT_W'(DEPTH);

    basilisk_mem_word_t r_buf [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] bump(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Upstream credit accounting guarantees a free slot for every push.
            assert (!(i_push && w_full));
            if (w_do_push) begin
                r_wr_ptr <= bump(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= bump(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - COUNT_W'(1);
            end
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_buf[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/basilisk_float_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : basilisk_float_mem_responder
// Description : Scratchpad responder for the Basilisk float memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module basilisk_float_mem_responder
    import basilisk_float_mem_responder_pkg::*;
#(
    parameter int    MEMORY_LATENCY = BASILISK_MEM_DEFAULT_LATENCY,
    parameter int    ADDR_WIDTH     = 10,
    parameter int    QUEUE_DEPTH    = MEMORY_LATENCY + 2,
    parameter string INIT_FILE      = ""
) (
    input  logic        clk,
    input  logic        rst,
    std_mem_intf.slave  mem_request,
    std_mem_intf.master mem_result
);
    localparam int                    c_credit_w    = $clog2(QUEUE_DEPTH + 1);
    localparam logic [c_credit_w-1:0] c_queue_depth = c_credit_w'(QUEUE_DEPTH);
    localparam int                    c_ram_depth   = 2 ** ADDR_WIDTH;

    basilisk_mem_word_t        r_mem [c_ram_depth];
    basilisk_mem_word_t        r_rd_data;
    basilisk_mem_word_t        w_tail_data;
    basilisk_mem_word_t        w_q_data;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [MEMORY_LATENCY-1:0] r_pipe_vld;
    logic [c_credit_w-1:0]     r_credit;
    logic [c_credit_w-1:0]     w_q_count;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_load_acc;
    logic                      w_store_acc;
    logic                      w_q_valid;
    logic                      w_res_valid;
    logic                      w_pop;

    // Ready depends only on outstanding credit so it can never combinationally
    // loop back through the requester's valid.
    assign w_addr      = mem_request.addr[ADDR_WIDTH-1:0];
    assign w_ready     = !rst && (r_credit < c_queue_depth);
    assign w_accept    = mem_request.valid && w_ready;
    assign w_load_acc  = w_accept && mem_request.read_enable;
    assign w_store_acc = w_accept && (mem_request.write_enable != '0);

    assign mem_request.ready = w_ready;

    // Read-first: a combined load/store returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (w_store_acc) begin
            for (int b = 0; b < c_mem_be_width; b++) begin
                if (mem_request.write_enable[b]) begin
                    r_mem[w_addr][8*b +: 8] <= mem_request.data[8*b +: 8];
                end
            end
        end
        if (w_load_acc) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_load_acc;
            for (int s = 1; s < MEMORY_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
            end
        end
    end

    // The RAM output register is the first latency stage; extra stages follow it.
    if (MEMORY_LATENCY == 1) begin : g_lat_one
        assign w_tail_data = r_rd_data;
    end else begin : g_lat_multi
        basilisk_mem_word_t r_shift [MEMORY_LATENCY-1];

        always_ff @(posedge clk) begin
            r_shift[0] <= r_rd_data;
            for (int s = 1; s < MEMORY_LATENCY - 1; s++) begin
                r_shift[s] <= r_shift[s-1];
            end
        end

        assign w_tail_data = r_shift[MEMORY_LATENCY-2];
    end

    basilisk_float_mem_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .COUNT_W (c_credit_w)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pipe_vld[MEMORY_LATENCY-1]),
        .i_data  (w_tail_data),
        .i_pop   (w_pop),
        .o_valid (w_q_valid),
        .o_data  (w_q_data),
        .o_count (w_q_count)
    );

    assign w_res_valid = !rst && w_q_valid;
    assign w_pop       = w_res_valid && mem_result.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            assert (w_q_count <= r_credit);
            if (w_load_acc && !w_pop) begin
                r_credit <= r_credit + c_credit_w'(1);
            end else if (!w_load_acc && w_pop) begin
                r_credit <= r_credit - c_credit_w'(1);
            end
        end
    end

    assign mem_result.valid        = w_res_valid;
    assign mem_result.data         = w_q_data;
    assign mem_result.read_enable  = 1'b0;
    assign mem_result.write_enable = '0;
    assign mem_result.addr         = '0;

endmodule
`default_nettype wire

// File: tb/tb_basilisk_float_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_basilisk_float_mem_responder
// Description : Self-checking bench for the float memory responder (L=1, L=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_basilisk_float_mem_responder;

    localparam int c_lat = 3;
    localparam int c_qd  = c_lat + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    std_mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) req1 ();
    std_mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) res1 ();
    std_mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) req3 ();
    std_mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) res3 ();

    basilisk_float_mem_responder #(.MEMORY_LATENCY(1), .ADDR_WIDTH(10)) dut1 (
        .clk(clk), .rst(rst), .mem_request(req1), .mem_result(res1)
    );
    basilisk_float_mem_responder #(.MEMORY_LATENCY(c_lat), .ADDR_WIDTH(10)) dut3 (
        .clk(clk), .rst(rst), .mem_request(req3), .mem_result(res3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f(input int i);
        return 32'h3F80_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Reference model for dut3: word array plus in-flight and response queues.
    typedef struct { int due; logic [31:0] data; } infl_t;
    logic [31:0] mmem [1024];
    infl_t       inflight [$];
    logic [31:0] resp [$];
    int          cyc = 0;

    function automatic bit m_ready();
        return !rst && (inflight.size() + resp.size() < c_qd);
    endfunction
    function automatic bit m_valid();
        return !rst && (resp.size() > 0);
    endfunction
    function automatic logic [31:0] m_data();
        return (resp.size() > 0) ? resp[0] : 32'h0;
    endfunction

    always @(posedge clk) begin
        bit acc, pop;
        int a;
        pop = m_valid() && res3.ready;
        acc = req3.valid && m_ready();
        if (rst) begin
            inflight.delete();
            resp.delete();
        end else begin
            if (pop) void'(resp.pop_front());
            while (inflight.size() > 0 && inflight[0].due == cyc) begin
                resp.push_back(inflight[0].data);
                void'(inflight.pop_front());
            end
            if (acc) begin
                a = int'(req3.addr);
                if (req3.read_enable) inflight.push_back('{cyc + c_lat, mmem[a]});
                for (int b = 0; b < 4; b++)
                    if (req3.write_enable[b]) mmem[a][8*b +: 8] = req3.data[8*b +: 8];
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        check("mdl_ready", {31'd0, req3.ready}, {31'd0, m_ready()});
        check("mdl_valid", {31'd0, res3.valid}, {31'd0, m_valid()});
        if (m_valid()) check("mdl_data", res3.data, m_data());
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        re;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];
    int   expq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle3();
        req3.valid = 1'b0; req3.read_enable = 1'b0; req3.write_enable = 4'h0;
    endtask

    task automatic load3(input int a);
        req3.valid = 1'b1; req3.read_enable = 1'b1; req3.write_enable = 4'h0;
        req3.addr = 10'(a); req3.data = 32'h0;
    endtask

    initial begin
        int nacc, a, got;

        vecs[0]  = '{1'b0, 4'hF, 10'd5,    32'h3F80_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 10'd5,    32'h0,         1'b1, 32'h3F80_0000};
        vecs[2]  = '{1'b0, 4'hF, 10'd9,    32'h1122_3344, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'h3, 10'd9,    32'hAAAA_BBBB, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 10'd9,    32'h0,         1'b1, 32'h1122_BBBB};
        vecs[5]  = '{1'b0, 4'hC, 10'd9,    32'hDEAD_0000, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 4'hF, 10'd9,    32'h0123_4567, 1'b1, 32'hDEAD_BBBB};
        vecs[7]  = '{1'b1, 4'h0, 10'd9,    32'h0,         1'b1, 32'h0123_4567};
        vecs[8]  = '{1'b0, 4'h0, 10'd9,    32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'hF, 10'd1023, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 10'd1023, 32'h0,         1'b1, 32'hCAFE_F00D};

        req1.valid = 1'b0; req1.read_enable = 1'b0; req1.write_enable = 4'h0;
        req1.addr = '0; req1.data = '0; res1.ready = 1'b1;
        req3.addr = '0; req3.data = '0; idle3(); res3.ready = 1'b1;

        // Reset behaviour
        rst = 1'b1;
        tick();
        check("rst_ready1", {31'd0, req1.ready}, 32'd0);
        check("rst_ready3", {31'd0, req3.ready}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready1", {31'd0, req1.ready}, 32'd1);
        check("post_rst_valid1", {31'd0, res1.valid}, 32'd0);

        // L=1 vector table
        for (int i = 0; i < 11; i++) begin
            req1.valid = 1'b1; req1.read_enable = vecs[i].re; req1.write_enable = vecs[i].we;
            req1.addr = vecs[i].addr; req1.data = vecs[i].wdata;
            check("d1_ready", {31'd0, req1.ready}, 32'd1);
            tick();
            req1.valid = 1'b0; req1.read_enable = 1'b0; req1.write_enable = 4'h0;
            check("d1_early", {31'd0, res1.valid}, 32'd0);
            tick();
            check("d1_valid", {31'd0, res1.valid}, {31'd0, vecs[i].exp_resp});
            if (vecs[i].exp_resp) check("d1_data", res1.data, vecs[i].exp_data);
        end

        // Prefill dut3 addresses 0..15
        for (int i = 0; i < 16; i++) begin
            req3.valid = 1'b1; req3.read_enable = 1'b0; req3.write_enable = 4'hF;
            req3.addr = 10'(i); req3.data = f(i);
            tick();
        end
        idle3();
        tick();

        // Back-to-back loads 0..7 with result ready held high
        res3.ready = 1'b1;
        load3(0);
        check("b2b_ready", {31'd0, req3.ready}, 32'd1);
        for (int t = 0; t < 13; t++) begin
            tick();
            if (t + 1 < 8) begin
                load3(t + 1);
                check("b2b_ready", {31'd0, req3.ready}, 32'd1);
            end else begin
                idle3();
            end
            check("b2b_valid", {31'd0, res3.valid}, {31'd0, (t >= c_lat && t <= c_lat + 7)});
            if (t >= c_lat && t <= c_lat + 7) check("b2b_data", res3.data, f(t - c_lat));
        end

        // Backpressure fill then drain
        res3.ready = 1'b0; nacc = 0; a = 0; expq.delete();
        for (int t = 0; t < 12; t++) begin
            load3(a);
            if (req3.ready) begin expq.push_back(a); nacc++; a++; end
            tick();
        end
        idle3();
        check("bp_accepted", 32'(nacc), 32'(c_qd));
        check("bp_ready_low", {31'd0, req3.ready}, 32'd0);
        res3.ready = 1'b1; got = 0;
        for (int t = 0; t < 20 && got < c_qd; t++) begin
            if (res3.valid) begin
                check("bp_drain_data", res3.data, f(expq.pop_front()));
                got++;
            end
            tick();
        end
        check("bp_drain_count", 32'(got), 32'(c_qd));
        tick(); tick();
        check("bp_no_dup", {31'd0, res3.valid}, 32'd0);
        check("bp_ready_back", {31'd0, req3.ready}, 32'd1);

        // Simultaneous pop and accept at credit == depth-1
        res3.ready = 1'b0;
        for (int i = 0; i < c_qd - 1; i++) begin load3(i); tick(); end
        idle3();
        for (int i = 0; i < c_lat + 1; i++) tick();
        check("pa_ready_pre", {31'd0, req3.ready}, 32'd1);
        check("pa_head_pre", res3.data, f(0));
        res3.ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            load3(c_qd - 1 + s);
            tick();
            check("pa_ready_hold", {31'd0, req3.ready}, 32'd1);
            check("pa_head", res3.data, f(s + 1));
        end
        idle3();
        for (int i = 0; i < 10; i++) tick();
        check("pa_drained", {31'd0, res3.valid}, 32'd0);

        // Reset with two loads in flight
        load3(1); tick();
        load3(2); tick();
        idle3();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, req3.ready}, 32'd0);
        check("mid_rst_valid", {31'd0, res3.valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("after_rst_ready", {31'd0, req3.ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("after_rst_silent", {31'd0, res3.valid}, 32'd0);
            tick();
        end
        load3(9);
        for (int t = 0; t < 6; t++) begin
            tick();
            idle3();
            check("after_rst_valid", {31'd0, res3.valid}, {31'd0, t == c_lat});
            if (t == c_lat) check("after_rst_data", res3.data, f(9));
        end

        // Randomised traffic, checked cycle by cycle against the model
        for (int t = 0; t < 400; t++) begin
            req3.valid = ($urandom_range(3) != 0);
            req3.read_enable = $urandom_range(1);
            case ($urandom_range(3))
                0, 1: req3.write_enable = 4'h0;
                2:    req3.write_enable = 4'hF;
                default: req3.write_enable = 4'($urandom_range(15));
            endcase
            req3.addr = 10'($urandom_range(15));
            req3.data = $urandom;
            res3.ready = ($urandom_range(3) != 0);
            tick();
        end
        idle3();
        res3.ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("rand_drained", {31'd0, res3.valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
